// File: rtl/shift_add_recombiner.sv
// Sequential shift-add multiply-accumulate: product = multiplier * multiplicand + addend.
// One multiplier bit is consumed per clock; latency is fixed at WIDTH cycles after acceptance.
// Rebuilds a dividend from divider results (quotient, divisor, remainder).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   start        request, sampled only while idle
//   multiplier   operand A (quotient)
//   multiplicand operand B (divisor)
//   addend       zero-extended additive term (remainder)
//   product      2*WIDTH result, held until the next completion
//   overflow     upper half of product is nonzero
//   busy         high while multiplying
//   valid        one-cycle completion pulse
module shift_add_recombiner #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     addend,
   output logic [2*WIDTH-1:0]   product,
   output logic                 overflow,
   output logic                 busy,
   output logic                 valid
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      MULT = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     mcand_r, mcand_nxt;
   logic [WIDTH-1:0]  mplier_r, mplier_nxt;
   logic [PW-1:0]     acc, acc_nxt;
   logic [CW-1:0]     count, count_nxt;
   logic [PW-1:0]     product_nxt;
   logic              overflow_nxt;
   logic              busy_nxt;
   logic              valid_nxt;
   logic [PW-1:0]     acc_sum;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc      <= '0;
         count    <= '0;
         product  <= '0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
      end else begin
         state    <= state_nxt;
         mcand_r  <= mcand_nxt;
         mplier_r <= mplier_nxt;
         acc      <= acc_nxt;
         count    <= count_nxt;
         product  <= product_nxt;
         overflow <= overflow_nxt;
         busy     <= busy_nxt;
         valid    <= valid_nxt;
      end
   end

   // Conditional partial-product add for the current multiplier LSB
   assign acc_sum = acc + (mplier_r[0] ? mcand_r : '0);

   // Next-state and output logic
   always_comb begin
      state_nxt    = state;
      mcand_nxt    = mcand_r;
      mplier_nxt   = mplier_r;
      acc_nxt      = acc;
      count_nxt    = count;
      product_nxt  = product;
      overflow_nxt = overflow;
      busy_nxt     = busy;
      valid_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               mcand_nxt  = {{WIDTH{1'b0}}, multiplicand};
               mplier_nxt = multiplier;
               acc_nxt    = {{WIDTH{1'b0}}, addend};
               count_nxt  = '0;
               busy_nxt   = 1'b1;
               state_nxt  = MULT;
            end
         end
         MULT: begin
            acc_nxt    = acc_sum;
            mcand_nxt  = mcand_r << 1;
            mplier_nxt = mplier_r >> 1;
            count_nxt  = CW'(count + CW'(1));
            // Last multiplier bit: publish the accumulator including this step's add
            if (count == CW'(WIDTH - 1)) begin
               product_nxt  = acc_sum;
               overflow_nxt = |acc_sum[PW-1:WIDTH];
               valid_nxt    = 1'b1;
               busy_nxt     = 1'b0;
               state_nxt    = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_add_recombiner.sv
// Self-checking bench for shift_add_recombiner (WIDTH=16): vector table, random
// operations against an arithmetic model, and multi-cycle corner sequences.
module tb_shift_add_recombiner;

   localparam int unsigned W = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  multiplier;
   logic [W-1:0]  multiplicand;
   logic [W-1:0]  addend;
   logic [2*W-1:0] product;
   logic          overflow;
   logic          busy;
   logic          valid;

   int total = 0;
   int bad   = 0;

   shift_add_recombiner #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .addend       (addend),
      .product      (product),
      .overflow     (overflow),
      .busy         (busy),
      .valid        (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [W-1:0]   c;
      logic [2*W-1:0] exp_p;
      logic           exp_ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Reference model: plain arithmetic on wide integers
   function automatic logic [63:0] model_p(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
      longint unsigned r;
      r = longint'(a) * longint'(b) + longint'(c);
      return 64'(r);
   endfunction

   // Issue one operation, scramble inputs after acceptance, and measure completion
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         output logic [2*W-1:0] p, output logic ovf, output int lat,
                         output int bcnt);
      @(negedge clk);
      multiplier = a; multiplicand = b; addend = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      multiplier = W'($urandom); multiplicand = W'($urandom); addend = W'($urandom);
      bcnt = busy ? 1 : 0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = n;
            break;
         end
         if (busy) bcnt++;
      end
      if (lat < 0) check("valid_timeout", 64'd0, 64'd1);
      p = product;
      ovf = overflow;
      check("busy_at_valid", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("valid_one_cycle", 64'(valid), 64'd0);
      check("product_held", 64'(product), 64'(p));
   endtask

   logic [2*W-1:0] p;
   logic           ovf;
   int             lat, bcnt, n_bad, vcount;
   logic [W-1:0]   ra, rb, rc;
   logic [63:0]    ref_p;

   initial begin
      vecs[0] = '{a: 16'd7,     b: 16'd5,     c: 16'd3,     exp_p: 32'd38,        exp_ovf: 1'b0};
      vecs[1] = '{a: 16'hFFFF,  b: 16'hFFFF,  c: 16'hFFFF,  exp_p: 32'hFFFF0000,  exp_ovf: 1'b1};
      vecs[2] = '{a: 16'd142,   b: 16'd7,     c: 16'd6,     exp_p: 32'd1000,      exp_ovf: 1'b0};
      vecs[3] = '{a: 16'd0,     b: 16'd0,     c: 16'd1234,  exp_p: 32'd1234,      exp_ovf: 1'b0};
      vecs[4] = '{a: 16'h0100,  b: 16'h0100,  c: 16'd0,     exp_p: 32'h00010000,  exp_ovf: 1'b1};
      vecs[5] = '{a: 16'd1,     b: 16'hFFFF,  c: 16'd0,     exp_p: 32'h0000FFFF,  exp_ovf: 1'b0};
      vecs[6] = '{a: 16'h8000,  b: 16'd2,     c: 16'hFFFF,  exp_p: 32'h0001FFFF,  exp_ovf: 1'b1};

      rst = 1'b0; start = 1'b0;
      multiplier = '0; multiplicand = '0; addend = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_product", 64'(product), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_valid", 64'(valid), 64'd0);
      @(negedge clk); rst = 1'b1;

      // Directed vector table
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].c, p, ovf, lat, bcnt);
         check($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].exp_p));
         check($sformatf("vec%0d_overflow", i), 64'(ovf), 64'(vecs[i].exp_ovf));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W));
         check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(W));
      end

      // Random operations against the arithmetic model
      for (int i = 0; i < 25; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
         if (i % 5 == 0) ra = W'($urandom_range(0, 3));
         ref_p = model_p(ra, rb, rc);
         run_op(ra, rb, rc, p, ovf, lat, bcnt);
         check($sformatf("rand%0d_product", i), 64'(p), ref_p);
         check($sformatf("rand%0d_overflow", i), 64'(ovf), 64'(ref_p[63:W] != 0));
         check($sformatf("rand%0d_latency", i), 64'(lat), 64'(W));
      end

      // Start while busy is ignored; start during valid is accepted
      @(negedge clk);
      multiplier = 16'd3; multiplicand = 16'd4; addend = 16'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      multiplier = 16'd9; multiplicand = 16'd9; addend = 16'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = -1;
      for (int n = 6; n <= 40; n++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = n;
            break;
         end
      end
      check("busy_prot_latency", 64'(lat), 64'(W));
      check("busy_prot_product", 64'(product), 64'd12);
      multiplier = 16'd9; multiplicand = 16'd9; addend = 16'd1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("b2b_accept_busy", 64'(busy), 64'd1);
      check("b2b_valid_low", 64'(valid), 64'd0);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = n;
            break;
         end
      end
      check("b2b_latency", 64'(lat), 64'(W));
      check("b2b_product", 64'(product), 64'd82);

      // Reset mid-operation abandons the computation
      @(negedge clk);
      multiplier = 16'd100; multiplicand = 16'd100; addend = 16'd0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_product", 64'(product), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_valid", 64'(valid), 64'd0);
      @(negedge clk); rst = 1'b1;
      vcount = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (valid) vcount++;
      end
      check("midrst_no_valid", 64'(vcount), 64'd0);

      // Result holds while idle
      run_op(16'd2, 16'd3, 16'd1, p, ovf, lat, bcnt);
      check("hold_initial", 64'(p), 64'd7);
      n_bad = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (product !== 32'd7 || valid !== 1'b0 || busy !== 1'b0) n_bad++;
      end
      check("hold_bad_cycles", 64'(n_bad), 64'd0);
      check("hold_final", 64'(product), 64'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_add_recombiner.md
Name: shift_add_recombiner

Overview:
- Sequential shift-add multiply-accumulate. Computes product = multiplier × multiplicand + addend, one multiplier bit per clock.
- This is the inverse of the restoring divider: it rebuilds dividend = quotient × divisor + remainder.
- Used as the on-chip result checker for the divider and as a general-purpose MAC for the board test top.
- Results feed the existing seven-segment display path.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- multiplier  input  WIDTH  operand A (divider quotient)
- multiplicand  input  WIDTH  operand B (divider divisor)
- addend  input  WIDTH  zero-extended additive term (divider remainder)
- product  output  2*WIDTH  result register; held until next accepted start
- overflow  output  1  product[2*WIDTH-1:WIDTH] != 0, registered alongside product
- busy  output  1  high while in MULT
- valid  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE; product=0, overflow=0, busy=0, valid=0.
  - Iteration counter and internal operand registers cleared.
  - Applies even mid-operation: the computation is abandoned and valid is never raised for it.
- States: IDLE, MULT.
- IDLE:
  - start==1 at edge E0 → latch mcand_r = {WIDTH'0, multiplicand}, mplier_r = multiplier, acc = {WIDTH'0, addend}, count = 0.
  - Same edge: busy<=1, state<=MULT.
  - start==0 → remain in IDLE; product and overflow hold their last values.
- MULT, each edge:
  - if mplier_r[0]==1, acc <= acc + mcand_r (2*WIDTH-bit add, no carry-out needed).
  - mcand_r <= mcand_r << 1; mplier_r <= mplier_r >> 1; count <= count + 1.
  - On the edge where count==WIDTH-1 (the WIDTH-th MULT edge, E16 for WIDTH=16):
    - product <= final acc; overflow <= |final acc[2*WIDTH-1:WIDTH].
    - valid <= 1, busy <= 0, state <= IDLE.
- Latency: valid is high in the cycle following edge E0+WIDTH, i.e. 17 edges after start for WIDTH=16. Latency is fixed and does not depend on the data; there is no early exit when the multiplier is 0.
- valid:
  - High for exactly one cycle, then low.
  - product must already be stable in that cycle.
- start while busy==1: ignored. No restart, no queuing, and no effect on operands, which are latched only at E0.
- start asserted in the same cycle as valid: accepted, because state is IDLE. Back-to-back operations therefore run at one every WIDTH+1 cycles.
- Operand inputs may change freely after E0.
- Arithmetic range:
  - Maximum result (2^W−1)^2 + (2^W−1) = 2^(2W) − 2^W, which always fits in 2*WIDTH bits. No wrap is possible.
  - overflow flags only that the result exceeds WIDTH bits, i.e. would not be a legal dividend.
- Divide-by-zero convention from the divider (quotient=0, remainder=dividend): multiplicand=0, multiplier=0 yields product=addend, overflow=0. No special case is required.
- count is $clog2(WIDTH)+1 bits wide.

Test Plan:
- Basic: multiplier=7, multiplicand=5, addend=3, start one cycle → valid exactly 17 edges later, product=38, overflow=0, busy high for 16 cycles.
- Max: multiplier=0xFFFF, multiplicand=0xFFFF, addend=0xFFFF → product=0xFFFF0000, overflow=1.
- Divider round trip: 1000/7 gives quotient=142, remainder=6 → multiplier=142, multiplicand=7, addend=6 → product=1000, overflow=0. Zero-divisor case: multiplier=0, multiplicand=0, addend=1234 → product=1234.
- Busy protection: start with 3×4+0, re-pulse start with 9×9+0 at cycle 5 → single valid, product=12. Then start asserted during the valid cycle with 9×9+1 → second valid 17 edges later, product=82.
- Reset mid-op: start 100×100+0, drive rst=0 at cycle 8 → next cycle product=0, busy=0, valid=0. No valid appears in the following 20 cycles unless start is reasserted.
- Hold: after a completed 2×3+1=7, keep start=0 for 50 cycles → product stays 7, valid stays 0.
